// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequenced 48x48 multiplier:
//   - state_t      : controller FSM states (IDLE, CALC, DONE)
//   - PKG_LEAF_W   : operand width of the leaf multiplier (24)
//   - PKG_OP_W     : wide operand width (48)
//   - PKG_PROD_W   : wide product width (96)
//   - step_shift() : left shift applied to the partial product of a step
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int PKG_LEAF_W = 24;
  localparam int PKG_OP_W   = 2 * PKG_LEAF_W;
  localparam int PKG_PROD_W = 2 * PKG_OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step encodes which operand halves are multiplied:
  //   bit0 selects the high half of b, bit1 selects the high half of a.
  // The shift is therefore LEAF_W per selected high half.
  function automatic logic [6:0] step_shift(input logic [1:0] step);
    logic [6:0] sh;
    case (step)
      2'd0:    sh = 7'd0;
      2'd1:    sh = 7'(PKG_LEAF_W);
      2'd2:    sh = 7'(PKG_LEAF_W);
      default: sh = 7'(2 * PKG_LEAF_W);
    endcase
    return sh;
  endfunction

endpackage : mult_pkg

// File: rtl/Dadda_Multiplier_24bit.sv
// -----------------------------------------------------------------------------
// Dadda_Multiplier_24bit
//   24x24 unsigned combinational leaf multiplier.
//   Ports:
//     in1 [23:0] : multiplicand
//     in2 [23:0] : multiplier
//     out [47:0] : in1 * in2, full width, no truncation
// -----------------------------------------------------------------------------
module Dadda_Multiplier_24bit (
  input  logic [23:0] in1,
  input  logic [23:0] in2,
  output logic [47:0] out
);

  // Both operands are widened first so the product is formed at full width.
  assign out = {24'b0, in1} * {24'b0, in2};

endmodule : Dadda_Multiplier_24bit

// File: rtl/mult48_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult48_seq_ctrl
//   48x48 unsigned multiplier built from a single 24x24 leaf multiplier that is
//   reused over four CALC cycles; partial products are accumulated at 96 bits.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     in_valid   : operand pair valid          in_ready  : operands accepted
//     a, b       : 48-bit unsigned operands
//     out_valid  : product valid               out_ready : consumer accepts
//     product    : 96-bit unsigned a*b, held stable while out_valid && !out_ready
//     busy       : high while in CALC or DONE
// -----------------------------------------------------------------------------
module mult48_seq_ctrl
  import mult_pkg::*;
#(
  parameter  int LEAF_W = 24,
  localparam int OP_W   = 2 * LEAF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] product,
  output logic              busy
);

  // The leaf is a fixed 24-bit block; any other width cannot be built.
  if (LEAF_W != PKG_LEAF_W) begin : g_bad_leaf_w
    $error("mult48_seq_ctrl: LEAF_W must be 24");
  end

  localparam int PROD_W = 2 * OP_W;

  state_t              state_q;
  logic [1:0]          step_q;
  logic [1:0]          step_d;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [PROD_W-1:0]   product_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [LEAF_W-1:0]   leaf_a;
  logic [LEAF_W-1:0]   leaf_b;
  logic [2*LEAF_W-1:0] leaf_p;
  logic [PROD_W-1:0]   pp_ext;

  // Leaf operands are held at zero outside CALC so the tree does not toggle.
  always_comb begin
    leaf_a = '0;
    leaf_b = '0;
    if (state_q == CALC) begin
      leaf_a = step_q[1] ? a_q[OP_W-1:LEAF_W] : a_q[LEAF_W-1:0];
      leaf_b = step_q[0] ? b_q[OP_W-1:LEAF_W] : b_q[LEAF_W-1:0];
    end
  end

  Dadda_Multiplier_24bit u_leaf (
    .in1 (leaf_a),
    .in2 (leaf_b),
    .out (leaf_p)
  );

  // Widen before shifting so the high partial product keeps all its bits.
  assign pp_ext = {{(PROD_W - 2*LEAF_W){1'b0}}, leaf_p};
  assign acc_d  = acc_q + (pp_ext << step_shift(step_q));
  assign step_d = step_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_d;
          if (step_q == 2'd3) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule : mult48_seq_ctrl

// File: tb/tb_mult48_seq_ctrl.sv
module tb_mult48_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] a;
  logic [47:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] product;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult48_seq_ctrl #(.LEAF_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  // Reference: the product of the two operands as plain 96-bit integers.
  function automatic logic [95:0] ref_mul(input logic [47:0] x, input logic [47:0] y);
    logic [95:0] xx;
    logic [95:0] yy;
    xx = {48'b0, x};
    yy = {48'b0, y};
    return xx * yy;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands for one edge, then
  // scrambles a/b so that later input changes would show up if not latched.
  task automatic accept(input logic [47:0] x, input logic [47:0] y);
    for (int n = 0; n < 20; n++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    chk("in_ready_before_accept", {95'b0, in_ready}, 96'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    b = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    chk("in_ready_after_accept", {95'b0, in_ready}, 96'd0);
    chk("busy_after_accept", {95'b0, busy}, 96'd1);
  endtask

  // Called #1 after the accepting edge; counts edges until out_valid.
  task automatic wait_valid(input logic [95:0] exp, input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 4) chk("in_ready_low_calc", {95'b0, in_ready}, 96'd0);
    end
    chk("latency", 96'(lat), 96'd4);
    chk(name, product, exp);
    chk("in_ready_low_done", {95'b0, in_ready}, 96'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", {95'b0, out_valid}, 96'd0);
    chk("in_ready_after_hs", {95'b0, in_ready}, 96'd1);
    chk("busy_after_hs", {95'b0, busy}, 96'd0);
  endtask

  task automatic run_op(input logic [47:0] x, input logic [47:0] y,
                        input logic [95:0] exp, input string name, input int hold);
    accept(x, y);
    wait_valid(exp, name);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {95'b0, out_valid}, 96'd1);
      chk("hold_product", product, exp);
    end
    $display("op %s a=%h b=%h product=%h expect=%h", name, x, y, product, exp);
    handshake();
  endtask

  typedef struct {
    string       name;
    logic [47:0] a;
    logic [47:0] b;
    logic [95:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] ra;
    logic [47:0] rb;
    logic [95:0] bp_exp;
    logic [95:0] bp_new_exp;
    bit          seen;

    vecs[0] = '{"one_x_one",  48'h000000000001, 48'h000000000001, 96'h000000000000000000000001, 0};
    vecs[1] = '{"max_x_max",  48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 96'hFFFFFFFFFFFE000000000001, 2};
    vecs[2] = '{"shift_24",   48'h000001000000, 48'h000000FFFFFF, 96'h000000000000FFFFFF000000, 1};
    vecs[3] = '{"zero_x_max", 48'h000000000000, 48'hFFFFFFFFFFFF, 96'h0, 0};
    vecs[4] = '{"hi_x_hi",    48'h800000000000, 48'h800000000000, 96'h400000000000000000000000, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {95'b0, in_ready}, 96'd1);
    chk("reset_out_valid", {95'b0, out_valid}, 96'd0);
    chk("reset_busy", {95'b0, busy}, 96'd0);
    chk("reset_product", product, 96'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, vecs[i].hold);

    // Asynchronous reset in DONE, checked before any clock edge.
    accept(48'h0000_0000_0003, 48'h0000_0000_0005);
    wait_valid(96'd15, "pre_async_reset");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", {95'b0, in_ready}, 96'd1);
    chk("async_rst_out_valid", {95'b0, out_valid}, 96'd0);
    chk("async_rst_busy", {95'b0, busy}, 96'd0);
    chk("async_rst_product", product, 96'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // Backpressure with a competing request pending.
    bp_exp     = ref_mul(48'hABCDEF012345, 48'h0F0F0F0F0F0F);
    bp_new_exp = ref_mul(48'h111111111111, 48'h222222222222);
    accept(48'hABCDEF012345, 48'h0F0F0F0F0F0F);
    wait_valid(bp_exp, "bp_first");
    in_valid = 1'b1; a = 48'h111111111111; b = 48'h222222222222;
    for (int h = 0; h < 10; h++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {95'b0, out_valid}, 96'd1);
      chk("bp_product", product, bp_exp);
      chk("bp_in_ready", {95'b0, in_ready}, 96'd0);
    end
    $display("op bp_first product=%h expect=%h", product, bp_exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {95'b0, in_ready}, 96'd1);
    chk("bp_release_out_valid", {95'b0, out_valid}, 96'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", {95'b0, in_ready}, 96'd0);
    chk("bp_new_busy", {95'b0, busy}, 96'd1);
    wait_valid(bp_new_exp, "bp_second");
    $display("op bp_second product=%h expect=%h", product, bp_new_exp);
    handshake();

    // Reset while CALC is on step 2: the op must vanish.
    accept(48'hFFFFFFFFFFFF, 48'h123456789ABC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("calc_rst_busy", {95'b0, busy}, 96'd0);
    chk("calc_rst_in_ready", {95'b0, in_ready}, 96'd1);
    chk("calc_rst_product", product, 96'd0);
    @(posedge clk); #3 rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("calc_rst_no_valid", {95'b0, seen}, 96'd0);
    $display("op calc_reset dropped out_valid_seen=%0d", seen);
    run_op(48'h123456789ABC, 48'hFEDCBA987654,
           ref_mul(48'h123456789ABC, 48'hFEDCBA987654), "post_reset", 0);

    for (int k = 0; k < 1000; k++) begin
      ra = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      rb = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      case ($urandom_range(0, 7))
        0: ra = 48'hFFFF_FFFF_FFFF;
        1: rb = 48'h0000_00FF_FFFF;
        2: ra = 48'hFFFF_FF00_0000;
        default: ;
      endcase
      run_op(ra, rb, ref_mul(ra, rb), "rand", int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mult48_seq_ctrl
